// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a one-deep valid/ready holding register.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between data and stop bits.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   rx         in  serial input, asynchronous to clk, idles high
//   data       out received byte, valid while valid=1
//   valid      out holding register full
//   ready      in  consumer takes data when valid && ready
//   frame_err  out one-cycle pulse, a stop bit sampled 0
//   parity_err out one-cycle pulse, parity mismatch (tied 0 without the macro)
//   overrun    out one-cycle pulse, good byte dropped because the holding register was full
//   busy       out receiver state is not IDLE
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MSB_FIRST    = 1,
    parameter int STOP_BITS    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t        state, next;
    logic [1:0]    sync;
    logic          rx_s, armed, ferr, half_hit, bit_hit, sample, done, fe, good;
    logic [TW-1:0] tick;
    logic [2:0]    idx;
    logic [7:0]    shreg;

    assign rx_s     = sync[1];
    assign busy     = state != IDLE;
    assign half_hit = tick == TW'(HALF - 1);
    assign bit_hit  = tick == TW'(CLKS_PER_BIT - 1);
    assign sample   = state == START ? half_hit : (state != IDLE && bit_hit);
    // Stop-bit error includes the final stop sample, which is not yet in ferr.
    assign fe       = ferr || !rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            state <= IDLE;
        end else begin
            sync  <= {sync[0], rx};
            state <= next;
        end
    end

    always_comb begin
        next = state;
        done = 1'b0;
        case (state)
            IDLE:  if (armed && !rx_s) next = START;
            START: if (half_hit) next = rx_s ? IDLE : DATA;
            DATA:
                if (bit_hit && idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                    next = PARITY;
            PARITY:
                if (bit_hit) next = STOP;
`else
                    next = STOP;
`endif
            STOP:
                if (bit_hit && idx == 3'(STOP_BITS - 1)) begin
                    next = IDLE;
                    done = 1'b1;
                end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick  <= '0;
            idx   <= 3'd0;
            shreg <= 8'h00;
            armed <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            tick  <= (state == IDLE || sample) ? '0 : tick + 1'b1;
            // idx wraps 7->0 after the last data bit, so it restarts for stop bits.
            idx   <= state == IDLE ? 3'd0 : (sample && (state == DATA || state == STOP)) ? idx + 3'd1 : idx;
            if (sample && state == DATA)
                shreg <= MSB_FIRST != 0 ? {shreg[6:0], rx_s} : {rx_s, shreg[7:1]};
            // Outside IDLE armed tracks the line, so returning to IDLE arms only if the
            // last sample was high; a low line (break) must go high before re-arming.
            armed <= (state == IDLE && armed) || rx_s;
            ferr  <= state != IDLE && (ferr || (sample && state == STOP && !rx_s));
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr;
    assign good = done && !fe && !perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            perr       <= state != IDLE && (perr || (sample && state == PARITY && rx_s != ^shreg));
            parity_err <= done && perr;
        end
    end
`else
    assign good       = done && !fe;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= done && fe;
            overrun   <= good && valid && !ready;
            if (good && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at default parameters.
module tb_uart_rx;
    localparam int N    = 16;
    localparam int HALF = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
    logic bad_par = 1'b0;
`else
    localparam int P = 0;
`endif
    // pin edge -> rx_s (2) + start sample (HALF) + 8 data, parity, 2 stop bits + 1 output register
    localparam int LAT = 3 + HALF + (9 + P + 1) * N;

    logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, overrun, busy;
    int         cyc = 0, passed = 0, total = 0, fe_n = 0, pe_n = 0, ov_n = 0, last_start = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] b2b[6] = '{8'h53, 8'h4D, 8'h31, 8'h39, 8'h32, 8'h38};

    uart_rx dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) begin
                got_q.push_back(data);
                got_cyc.push_back(cyc);
            end
            if (frame_err) fe_n++;
            if (parity_err) pe_n++;
            if (overrun) ov_n++;
        end
    end

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
        fe_n = 0;
        pe_n = 0;
        ov_n = 0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 ready = r;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        last_start = cyc;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[7-i];
            repeat (N) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b ^ bad_par;
        repeat (N) @(negedge clk);
`endif
        for (int k = 0; k < 2; k++) begin
            rx = stop_val;
            repeat (N) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        total++; if (data !== 8'h00) $display("FAIL reset_data got %h want 00", data); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if ({frame_err, parity_err, overrun} !== 3'b000)
            $display("FAIL reset_pulses got %b want 000", {frame_err, parity_err, overrun}); else passed++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int st;
        clear_log();
        send_byte(8'h53, 1'b1);
        st = last_start;
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 1) $display("FAIL single_count got %0d want 1", got_q.size()); else passed++;
        total++; if (got_q[0] !== 8'h53) $display("FAIL single_data got %h want 53", got_q[0]); else passed++;
        total++; if (got_cyc[0] !== st + LAT) $display("FAIL single_latency got %0d want %0d", got_cyc[0] - st, LAT); else passed++;
        total++; if (fe_n + pe_n + ov_n !== 0) $display("FAIL single_flags got %0d want 0", fe_n + pe_n + ov_n); else passed++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        for (int i = 0; i < 6; i++) send_byte(b2b[i], 1'b1);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 6) $display("FAIL b2b_count got %0d want 6", got_q.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++; if (got_q[i] !== b2b[i]) $display("FAIL b2b_data%0d got %h want %h", i, got_q[i], b2b[i]); else passed++;
        end
        total++; if (fe_n + pe_n + ov_n !== 0) $display("FAIL b2b_flags got %0d want 0", fe_n + pe_n + ov_n); else passed++;
    endtask

    task automatic test_glitch();
        clear_log();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL glitch_busy_e8 got %b want 1", busy); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL glitch_busy_e9 got %b want 0", busy); else passed++;
        repeat (3 * N) @(negedge clk);
        total++; if (got_q.size() + fe_n + pe_n + ov_n !== 0)
            $display("FAIL glitch_quiet got %0d want 0", got_q.size() + fe_n + pe_n + ov_n); else passed++;
    endtask

    task automatic test_frame_err();
        int bcnt = 0;
        clear_log();
        send_byte(8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        total++; if (fe_n !== 1) $display("FAIL ferr_pulse got %0d want 1", fe_n); else passed++;
        total++; if (got_q.size() !== 0) $display("FAIL ferr_novalid got %0d want 0", got_q.size()); else passed++;
        repeat (3 * N) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        total++; if (bcnt !== 0) $display("FAIL ferr_break_ignored got %0d want 0", bcnt); else passed++;
        rx = 1'b1;
        repeat (N) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C)
            $display("FAIL ferr_recover got %h want 3c", got_q[0]); else passed++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_log();
        bad_par = 1'b1;
        send_byte(8'hA5, 1'b1);
        bad_par = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (pe_n !== 1) $display("FAIL parity_pulse got %0d want 1", pe_n); else passed++;
        total++; if (got_q.size() + fe_n !== 0) $display("FAIL parity_discard got %0d want 0", got_q.size() + fe_n); else passed++;
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'hA5) $display("FAIL parity_good got %h want a5", got_q[0]); else passed++;
    endtask
`endif

    task automatic test_overrun();
        clear_log();
        set_ready(1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (valid !== 1'b1) $display("FAIL ovr_valid_held got %b want 1", valid); else passed++;
        total++; if (data !== 8'h11) $display("FAIL ovr_data_held got %h want 11", data); else passed++;
        total++; if (ov_n !== 1) $display("FAIL ovr_pulse got %0d want 1", ov_n); else passed++;
        set_ready(1'b1);
        set_ready(1'b0);
        total++; if (valid !== 1'b0) $display("FAIL ovr_valid_clear got %b want 0", valid); else passed++;
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h11) $display("FAIL ovr_accept got %h want 11", got_q[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        send_byte(8'h4D, 1'b1);
        repeat (4) @(negedge clk);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        rx = 1'b1;
        repeat (N) @(negedge clk);
        total++; if (busy !== 1'b1 || valid !== 1'b1) $display("FAIL rstmid_pre got %b%b want 11", busy, valid); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (data !== 8'h00) $display("FAIL rstmid_data got %h want 00", data); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_ready(1'b1);
        repeat (4) @(negedge clk);
        clear_log();
        send_byte(8'h4D, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h4D) $display("FAIL rstmid_next got %h want 4d", got_q[0]); else passed++;
        total++; if (fe_n + pe_n + ov_n !== 0) $display("FAIL rstmid_flags got %0d want 0", fe_n + pe_n + ov_n); else passed++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
